// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: controller command codes,
// arbiter FSM states and grant owner identifiers.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        RwIdle  = 2'd0,
        RwRead  = 2'd1,
        RwWrite = 2'd2
    } rw_flag_e;

    typedef enum logic [1:0] {
        ArbIdle   = 2'd0,
        ArbAccess = 2'd1,
        ArbResp   = 2'd2
    } arb_state_e;

    typedef enum logic {
        GrantIf = 1'b0,
        GrantD  = 1'b1
    } grant_e;

    localparam int SEL_W = 4;

    function automatic rw_flag_e rw_of(input logic we);
        return we ? RwWrite : RwRead;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_grant.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// the port that did not win last time.
module mem_rr_grant
    import mem_port_arbiter_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  grant_e last_grant,
    output logic   grant_valid,
    output logic   grant_d
);

    always_comb begin
        grant_valid = if_req | d_req;
        if (if_req && d_req) begin
            grant_d = (last_grant == GrantIf);
        end else begin
            grant_d = d_req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory-controller channel between the instruction-fetch and
// load/store ports, latching each granted command and returning read data.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [SEL_W-1:0]  d_sel,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_req,
    output logic [1:0]        mc_rw_flag,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_wdata,
    output logic [SEL_W-1:0]  mc_wmask,
    input  logic [DATA_W-1:0] mc_rdata,
    input  logic              mc_busy,
    input  logic              mc_done
);

    arb_state_e        state;
    arb_state_e        next_state;
    grant_e            last_grant;
    logic              grant_valid;
    logic              grant_d;
    logic              issue;
    logic              finish;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_we;
    logic [DATA_W-1:0] cmd_wdata;
    logic [SEL_W-1:0]  cmd_sel;

    mem_rr_grant u_grant (
        .if_req      (if_req),
        .d_req       (d_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_d     (grant_d)
    );

    // Requests and busy only matter in IDLE; done only matters in ACCESS.
    assign issue  = (state == ArbIdle) && grant_valid && !mc_busy;
    assign finish = (state == ArbAccess) && mc_done;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ArbIdle;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ArbIdle:   if (issue) next_state = ArbAccess;
            ArbAccess: if (mc_done) next_state = ArbResp;
            ArbResp:   next_state = ArbIdle;
            default:   next_state = ArbIdle;
        endcase
    end

    always_comb begin
        mc_rw_flag = RwIdle;
        mc_addr    = '0;
        mc_wdata   = '0;
        mc_wmask   = '0;
        if_ack     = 1'b0;
        d_ack      = 1'b0;
        case (state)
            ArbAccess: begin
                mc_rw_flag = rw_of(cmd_we);
                mc_addr    = cmd_addr;
                mc_wdata   = cmd_wdata;
                mc_wmask   = cmd_sel;
            end
            ArbResp: begin
                if_ack = (last_grant == GrantIf);
                d_ack  = (last_grant == GrantD);
            end
            default: ;
        endcase
    end

    // last_grant doubles as the owner of the transaction in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant <= GrantIf;
            cmd_addr   <= '0;
            cmd_we     <= 1'b0;
            cmd_wdata  <= '0;
            cmd_sel    <= '0;
        end else if (issue) begin
            if (grant_d) begin
                last_grant <= GrantD;
                cmd_addr   <= d_addr;
                cmd_we     <= d_we;
                cmd_wdata  <= d_we ? d_wdata : '0;
                cmd_sel    <= d_we ? d_sel : '0;
            end else begin
                last_grant <= GrantIf;
                cmd_addr   <= if_addr;
                cmd_we     <= 1'b0;
                cmd_wdata  <= '0;
                cmd_sel    <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (finish) begin
            if (last_grant == GrantIf) begin
                if_rdata <= mc_rdata;
            end else if (!cmd_we) begin
                d_rdata <= mc_rdata;
            end
        end
    end

    assign stall_req = (if_req & ~if_ack) | (d_req & ~d_ack);

    a_ack_exclusive: assert property (@(posedge CLK) !(if_ack && d_ack));
    a_rw_legal:      assert property (@(posedge CLK) mc_rw_flag != 2'd3);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              RST;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_sel;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              stall_req;
    logic [1:0]        mc_rw_flag;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_wdata;
    logic [3:0]        mc_wmask;
    logic [DATA_W-1:0] mc_rdata;
    logic              mc_busy;
    logic              mc_done;

    int errors = 0;
    int checks = 0;

    // Reference model: who won last (0 = fetch, 1 = data) and the read data
    // each port should currently be presenting.
    int          m_last;
    logic [31:0] m_if_rdata;
    logic [31:0] m_d_rdata;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
        .d_ack(d_ack), .d_rdata(d_rdata), .stall_req(stall_req),
        .mc_rw_flag(mc_rw_flag), .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_wmask(mc_wmask),
        .mc_rdata(mc_rdata), .mc_busy(mc_busy), .mc_done(mc_done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        d_sel = '0; mc_rdata = '0; mc_busy = 0; mc_done = 0;
    endtask

    task automatic model_reset();
        m_last = 0; m_if_rdata = '0; m_d_rdata = '0;
    endtask

    task automatic test_reset();
        RST = 1; clear_inputs();
        tick(); tick();
        RST = 0; #1;
        model_reset();
        checks++; if (mc_rw_flag !== 2'd0) begin errors++; $display("[TB] FAIL reset_rw got=%0d exp=0", mc_rw_flag); end
        checks++; if (mc_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got=%h exp=0", mc_addr); end
        checks++; if (mc_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata got=%h exp=0", mc_wdata); end
        checks++; if (mc_wmask !== 4'h0) begin errors++; $display("[TB] FAIL reset_wmask got=%h exp=0", mc_wmask); end
        checks++; if ({if_ack, d_ack} !== 2'b00) begin errors++; $display("[TB] FAIL reset_acks got=%b exp=00", {if_ack, d_ack}); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got=%h/%h exp=0/0", if_rdata, d_rdata); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%b exp=0", stall_req); end
    endtask

    task automatic test_single_fetch();
        if_addr = 32'h100; if_req = 1;
        tick();
        checks++; if (mc_rw_flag !== 2'd1 || mc_addr !== 32'h100) begin errors++; $display("[TB] FAIL fetch_cmd got rw=%0d addr=%h exp rw=1 addr=100", mc_rw_flag, mc_addr); end
        checks++; if (mc_wmask !== 4'h0 || mc_wdata !== 32'h0) begin errors++; $display("[TB] FAIL fetch_rdfields got mask=%h wdata=%h exp 0/0", mc_wmask, mc_wdata); end
        checks++; if (stall_req !== 1'b1) begin errors++; $display("[TB] FAIL fetch_stall got=%b exp=1", stall_req); end
        tick(); tick();
        mc_done = 1; mc_rdata = 32'hDEADBEEF;
        tick();
        mc_done = 0; mc_rdata = 32'h0BAD0BAD;
        checks++; if ({if_ack, d_ack} !== 2'b10) begin errors++; $display("[TB] FAIL fetch_ack got=%b exp=10", {if_ack, d_ack}); end
        checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL fetch_rdata got=%h exp=deadbeef", if_rdata); end
        checks++; if (mc_rw_flag !== 2'd0) begin errors++; $display("[TB] FAIL fetch_resp_rw got=%0d exp=0", mc_rw_flag); end
        if_req = 0; #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("[TB] FAIL fetch_stall_after got=%b exp=0", stall_req); end
        tick();
        checks++; if (if_ack !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL fetch_hold got ack=%b rdata=%h exp 0/deadbeef", if_ack, if_rdata); end
        m_last = 0; m_if_rdata = 32'hDEADBEEF;
    endtask

    task automatic test_random(input int n);
        for (int t = 0; t < n; t++) begin
            logic        ri, rq, we;
            logic [31:0] ia, da, wd, rdv, e_addr, e_wdata;
            logic [3:0]  sel, e_mask;
            logic [1:0]  e_rw;
            int          lat, win;
            ri = 1'($urandom_range(0, 1)); rq = 1'($urandom_range(0, 1));
            if (!ri && !rq) begin ri = 1; rq = 1; end
            we = 1'($urandom_range(0, 1)); sel = 4'($urandom_range(0, 15));
            ia = $urandom; da = $urandom; wd = $urandom; rdv = $urandom;
            lat = $urandom_range(0, 3);
            if (ri && rq) win = 1 - m_last; else win = rq ? 1 : 0;
            if (win == 0) begin e_rw = 2'd1; e_addr = ia; e_wdata = 0; e_mask = 0; end
            else if (we) begin e_rw = 2'd2; e_addr = da; e_wdata = wd; e_mask = sel; end
            else begin e_rw = 2'd1; e_addr = da; e_wdata = 0; e_mask = 0; end
            if_req = ri; if_addr = ia; d_req = rq; d_we = we; d_addr = da; d_wdata = wd; d_sel = sel;
            tick();
            for (int c = 0; c <= lat; c++) begin
                checks++;
                if ({mc_rw_flag, mc_addr, mc_wdata, mc_wmask} !== {e_rw, e_addr, e_wdata, e_mask}) begin
                    errors++;
                    $display("[TB] FAIL rand_cmd t=%0d got rw=%0d a=%h w=%h m=%h exp rw=%0d a=%h w=%h m=%h",
                             t, mc_rw_flag, mc_addr, mc_wdata, mc_wmask, e_rw, e_addr, e_wdata, e_mask);
                end
                checks++; if ({if_ack, d_ack, stall_req} !== 3'b001) begin errors++; $display("[TB] FAIL rand_access t=%0d got ack/ack/stall=%b exp=001", t, {if_ack, d_ack, stall_req}); end
                if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
                d_sel = 4'($urandom_range(0, 15)); d_we = 1'($urandom_range(0, 1));
                if (c == lat) begin mc_done = 1; mc_rdata = rdv; end
                tick();
            end
            mc_done = 0; mc_rdata = $urandom;
            m_last = win;
            if (win == 0) m_if_rdata = rdv; else if (!we) m_d_rdata = rdv;
            checks++; if ({if_ack, d_ack} !== ((win == 1) ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL rand_ack t=%0d got=%b win=%0d", t, {if_ack, d_ack}, win); end
            checks++; if (if_rdata !== m_if_rdata || d_rdata !== m_d_rdata) begin errors++; $display("[TB] FAIL rand_rdata t=%0d got=%h/%h exp=%h/%h", t, if_rdata, d_rdata, m_if_rdata, m_d_rdata); end
            checks++; if (mc_rw_flag !== 2'd0) begin errors++; $display("[TB] FAIL rand_resp_rw t=%0d got=%0d exp=0", t, mc_rw_flag); end
            if_req = 0; d_req = 0;
            tick();
        end
    endtask

    task automatic test_data_write();
        logic [31:0] old_d;
        old_d = m_d_rdata;
        d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'h12345678; d_sel = 4'b0011;
        tick();
        checks++; if ({mc_rw_flag, mc_addr, mc_wdata, mc_wmask} !== {2'd2, 32'h2004, 32'h12345678, 4'b0011}) begin
            errors++; $display("[TB] FAIL write_cmd got rw=%0d a=%h w=%h m=%b", mc_rw_flag, mc_addr, mc_wdata, mc_wmask); end
        tick();
        mc_done = 1; mc_rdata = 32'hA5A5_5A5A;
        tick();
        mc_done = 0;
        checks++; if ({if_ack, d_ack} !== 2'b01) begin errors++; $display("[TB] FAIL write_ack got=%b exp=01", {if_ack, d_ack}); end
        checks++; if (d_rdata !== old_d) begin errors++; $display("[TB] FAIL write_rdata got=%h exp=%h", d_rdata, old_d); end
        d_req = 0; d_we = 0;
        tick();
        checks++; if (d_ack !== 1'b0) begin errors++; $display("[TB] FAIL write_ack_pulse got=%b exp=0", d_ack); end
        m_last = 1;
    endtask

    task automatic test_busy();
        logic [31:0] a, r;
        a = $urandom; r = $urandom;
        mc_busy = 1; if_req = 1; if_addr = a;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (mc_rw_flag !== 2'd0 || stall_req !== 1'b1) begin errors++; $display("[TB] FAIL busy_hold i=%0d got rw=%0d stall=%b exp 0/1", i, mc_rw_flag, stall_req); end
        end
        mc_busy = 0;
        tick();
        checks++; if (mc_rw_flag !== 2'd1 || mc_addr !== a) begin errors++; $display("[TB] FAIL busy_issue got rw=%0d a=%h exp 1/%h", mc_rw_flag, mc_addr, a); end
        mc_busy = 1; mc_done = 1; mc_rdata = r;
        tick();
        mc_done = 0; mc_busy = 0;
        checks++; if (if_ack !== 1'b1 || if_rdata !== r) begin errors++; $display("[TB] FAIL busy_ack got ack=%b rdata=%h exp 1/%h", if_ack, if_rdata, r); end
        if_req = 0;
        tick();
        m_last = 0; m_if_rdata = r;
    endtask

    task automatic test_mid_change();
        logic [31:0] a, r;
        a = $urandom; r = $urandom;
        d_req = 1; d_we = 0; d_addr = a;
        tick();
        d_addr = ~a; d_we = 1; d_sel = 4'hF; d_wdata = $urandom; #1;
        checks++; if (mc_addr !== a || mc_rw_flag !== 2'd1 || mc_wmask !== 4'h0) begin errors++; $display("[TB] FAIL mid_latch got a=%h rw=%0d m=%h exp %h/1/0", mc_addr, mc_rw_flag, mc_wmask, a); end
        tick();
        checks++; if (mc_addr !== a) begin errors++; $display("[TB] FAIL mid_latch2 got=%h exp=%h", mc_addr, a); end
        mc_done = 1; mc_rdata = r;
        tick();
        mc_done = 0;
        checks++; if (d_ack !== 1'b1 || d_rdata !== r) begin errors++; $display("[TB] FAIL mid_ack got ack=%b rdata=%h exp 1/%h", d_ack, d_rdata, r); end
        d_req = 0; d_we = 0;
        m_last = 1; m_d_rdata = r;
        tick();
        mc_done = 1; mc_rdata = $urandom;
        tick();
        mc_done = 0;
        for (int i = 0; i < 2; i++) begin
            checks++; if ({if_ack, d_ack, mc_rw_flag} !== 4'b0000 || d_rdata !== m_d_rdata) begin errors++; $display("[TB] FAIL spurious_done i=%0d got acks=%b rw=%0d rdata=%h", i, {if_ack, d_ack}, mc_rw_flag, d_rdata); end
            tick();
        end
        if_req = 1; if_addr = a;
        tick();
        checks++; if (mc_rw_flag !== 2'd1 || mc_addr !== a) begin errors++; $display("[TB] FAIL spurious_next got rw=%0d a=%h exp 1/%h", mc_rw_flag, mc_addr, a); end
        mc_done = 1; mc_rdata = r;
        tick();
        mc_done = 0; if_req = 0;
        m_last = 0; m_if_rdata = r;
        tick();
    endtask

    task automatic test_round_robin();
        logic [31:0] ia, da, r;
        int          w, win;
        RST = 1; clear_inputs();
        tick();
        RST = 0; model_reset();
        ia = 32'h0000_1000; da = 32'h0000_8000;
        if_addr = ia; d_addr = da; if_req = 1; d_req = 1;
        for (int i = 0; i < 4; i++) begin
            win = 1 - m_last;
            w = 0;
            tick();
            while (mc_rw_flag === 2'd0 && w < 4) begin tick(); w++; end
            checks++; if (mc_addr !== ((win == 1) ? da : ia) || mc_rw_flag !== 2'd1) begin errors++; $display("[TB] FAIL rr_grant i=%0d got a=%h rw=%0d exp win=%0d", i, mc_addr, mc_rw_flag, win); end
            checks++; if (stall_req !== 1'b1) begin errors++; $display("[TB] FAIL rr_stall i=%0d got=%b exp=1", i, stall_req); end
            repeat ($urandom_range(0, 2)) tick();
            r = $urandom;
            mc_done = 1; mc_rdata = r;
            tick();
            mc_done = 0;
            m_last = win;
            if (win == 1) m_d_rdata = r; else m_if_rdata = r;
            checks++; if ({if_ack, d_ack} !== ((win == 1) ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL rr_ack i=%0d got=%b win=%0d", i, {if_ack, d_ack}, win); end
            checks++; if (if_rdata !== m_if_rdata || d_rdata !== m_d_rdata) begin errors++; $display("[TB] FAIL rr_rdata i=%0d got=%h/%h exp=%h/%h", i, if_rdata, d_rdata, m_if_rdata, m_d_rdata); end
            tick();
            checks++; if ({if_ack, d_ack} !== 2'b00) begin errors++; $display("[TB] FAIL rr_once i=%0d got=%b exp=00", i, {if_ack, d_ack}); end
        end
        if_req = 0; d_req = 0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] a, r;
        a = $urandom; r = $urandom;
        d_req = 1; d_we = 1; d_addr = $urandom; d_wdata = $urandom; d_sel = 4'hC;
        tick();
        checks++; if (mc_rw_flag !== 2'd2) begin errors++; $display("[TB] FAIL rst_mid_issue got=%0d exp=2", mc_rw_flag); end
        tick();
        RST = 1;
        tick();
        RST = 0; d_req = 0; d_we = 0; #1;
        model_reset();
        checks++; if ({mc_rw_flag, if_ack, d_ack} !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mid_idle got rw=%0d acks=%b", mc_rw_flag, {if_ack, d_ack}); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_rdata got=%h/%h exp=0/0", if_rdata, d_rdata); end
        tick();
        checks++; if ({mc_rw_flag, if_ack, d_ack} !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mid_noack got rw=%0d acks=%b", mc_rw_flag, {if_ack, d_ack}); end
        if_req = 1; if_addr = a;
        tick();
        checks++; if (mc_rw_flag !== 2'd1 || mc_addr !== a) begin errors++; $display("[TB] FAIL rst_mid_fetch got rw=%0d a=%h exp 1/%h", mc_rw_flag, mc_addr, a); end
        mc_done = 1; mc_rdata = r;
        tick();
        mc_done = 0;
        checks++; if (if_ack !== 1'b1 || if_rdata !== r) begin errors++; $display("[TB] FAIL rst_mid_ack got ack=%b rdata=%h exp 1/%h", if_ack, if_rdata, r); end
        if_req = 0;
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        RST = 1;
        clear_inputs();
        model_reset();
        tick();
        test_reset();
        test_single_fetch();
        test_random(24);
        test_data_write();
        test_busy();
        test_mid_change();
        test_round_robin();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one memory-controller channel between two requesters:
  - the CPU instruction-fetch port;
  - the CPU load/store port.
- Owns the controller handshake (rw_flag/busy/done), latches each granted request, returns read data and a one-cycle acknowledge, and drives a pipeline stall.
- Sits between the openrisc core ports and the memory controller inside the CPU core wrapper.

## Interface
Clock and reset: one clock `CLK`; reset `RST` is synchronous and active-high.

Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  synchronous active-high reset
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_sel  in  4  byte-lane enables for writes
- d_ack  out  1  one-cycle pulse; d_rdata valid for reads
- d_rdata  out  DATA_W  load data
- stall_req  out  1  pipeline stall
- mc_rw_flag  out  2  0 idle, 1 read, 2 write
- mc_addr  out  ADDR_W  controller address
- mc_wdata  out  DATA_W  controller write data
- mc_wmask  out  4  controller byte mask
- mc_rdata  in  DATA_W  controller read data, valid in the mc_done cycle
- mc_busy  in  1  controller cannot accept a new command
- mc_done  in  1  one-cycle pulse, transaction complete

## Operation
FSM states and transitions:
- IDLE
  - Goes to ACCESS when (if_req | d_req) & !mc_busy.
  - On that edge, latches the winner's command: addr, we, wdata, sel.
  - Records the grant owner.
- ACCESS
  - Drives mc_rw_flag, mc_addr, mc_wdata and mc_wmask from the latched command.
  - Goes to RESP on mc_done.
  - On that edge, captures mc_rdata into the owner's rdata register.
- RESP
  - Pulses the owner's ack for one cycle.
  - mc_rw_flag = 0.
  - Goes to IDLE unconditionally.

Arbitration:
- Round-robin, tracked by register last_grant.
- If both requests are present, grant the port ≠ last_grant.
- A single request wins outright.
- last_grant resets to IF, so data wins the first tie.

Command encoding:
- Read: mc_rw_flag = 1, mc_wmask = 0, mc_wdata = 0.
- Write: mc_rw_flag = 2, mc_wmask = d_sel.
- Fetches are always reads.
- A write with d_sel = 0 is still issued.

Other rules:
- Addresses pass through unmodified; no alignment checking.
- if_rdata and d_rdata hold their last captured value until the next capture for that port. A data write does not update d_rdata.
- stall_req = (if_req & !if_ack) | (d_req & !d_ack). This is combinational.
- mc_done outside ACCESS is ignored.
- mc_busy is sampled only in IDLE.
- Request inputs are ignored outside IDLE. The latched command is immune to input changes mid-transaction.
- A requester still asserting req in the cycle after its ack presents a new request. That request is arbitrated in IDLE.

## Timing
Reset (RST high at an edge):
- State → IDLE, last_grant → IF.
- mc_rw_flag, mc_addr, mc_wdata, mc_wmask, if_ack, d_ack, if_rdata and d_rdata all → 0.
- An in-flight transaction is abandoned; the controller is reset by the same RST.

Cycle-level sequence:
- req seen in IDLE at edge n.
- mc_rw_flag ≠ 0 from cycle n+1.
- mc_done in cycle k (k ≥ n+1); mc_rw_flag = 0 from cycle k+1.
- ack high in cycle k+1.
- IDLE in cycle k+2, so the next grant is earliest at the edge ending k+2.

Latency and throughput:
- Minimum request-to-ack latency: 2 cycles (done in the first ACCESS cycle).
- Back-to-back throughput: 1 transaction per 3 + controller-latency cycles.
- Under continuous dual requests, IF and D alternate strictly; no starvation.

## Structure
- Add to defines.v:
  - RwIdle/RwRead/RwWrite (2'd0/1/2);
  - state encodings ArbIdle/ArbAccess/ArbResp;
  - GrantIf/GrantD.
- Sub-module mem_rr_grant: combinational two-way round-robin picker.
  - Inputs: if_req, d_req, last_grant.
  - Outputs: grant_valid, grant_d.
- FSM, command latch and response registers stay in mem_port_arbiter.

## Test plan
- Reset mid-ACCESS (write issued, RST before mc_done) → next cycle mc_rw_flag = 0, no ack, state IDLE; a following fetch is granted normally.
- Single fetch if_addr = 0x100, mc_done 3 cycles later with mc_rdata = 0xDEADBEEF → mc_rw_flag = 1, mc_addr = 0x100, if_ack one cycle after done, if_rdata = 0xDEADBEEF, stall_req low after ack.
- Data write d_addr = 0x2004, d_wdata = 0x12345678, d_sel = 4'b0011 → mc_rw_flag = 2, mc_wmask = 0011, d_ack pulse; d_rdata unchanged.
- if_req and d_req asserted together from reset, held continuously → grant order D, IF, D, IF; each ack exactly once per mc_done.
- mc_busy = 1 for 5 cycles with if_req high → mc_rw_flag stays 0 and stall_req = 1 until busy drops; issue occurs on the next edge.
- Change d_addr mid-ACCESS, plus a spurious mc_done in IDLE → mc_addr keeps the latched value; the spurious done produces no ack and no state change.
